piezo_alert_sched: RTL

- Priority scheduler that arbitrates the three alert sources (too_fast, batt_low, en_steer) and sequences individual note commands to a downstream single-note tone generator.
- Owns priority, the 3 s repeat gap, note ordering and preemption; the tone generator only plays one (period, duration) note per command.
- Sits between the balance/steering status logic and the piezo output stage.

---
 rtl/piezo_alert_sched.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/piezo_alert_sched.sv
// piezo_alert_sched: arbitrates too_fast/batt_low/en_steer alerts and
// sequences single-note commands (period, duration) to a tone generator.
// Ports: clk, rst (sync, active-high); too_fast, batt_low, en_steer
// requests; note_rdy/note_done from the tone generator; note_vld,
// note_period[14:0], note_dur[25:0], note_abort, seq_id[1:0], busy out.
// Optional macro PIEZO_ABORT_EN: a rising too_fast aborts a playing
// BATT/FANFARE note immediately instead of waiting for note_done.
module piezo_alert_sched #(
  parameter bit          FAST_SIM    = 1'b1,
  parameter int unsigned REPEAT_CLKS = 150000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        too_fast,
  input  logic        batt_low,
  input  logic        en_steer,
  input  logic        note_rdy,
  input  logic        note_done,
  output logic        note_vld,
  output logic [14:0] note_period,
  output logic [25:0] note_dur,
  output logic        note_abort,
  output logic [1:0]  seq_id,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] SEQ_NONE = 2'd0;
  localparam logic [1:0] SEQ_WARN = 2'd1;
  localparam logic [1:0] SEQ_BATT = 2'd2;
  localparam logic [1:0] SEQ_FAN  = 2'd3;

  localparam logic [27:0] REPEAT = 28'(REPEAT_CLKS);
  localparam logic [27:0] INC    = FAST_SIM ? 28'd64 : 28'd1;

  state_t      state_q, state_d;
  logic [1:0]  seq_q, seq_d;
  logic [2:0]  step_q, step_d;
  logic [14:0] period_q, period_d;
  logic [25:0] dur_q, dur_d;
  logic [27:0] gap_q, gap_d;
  logic [28:0] gap_sum;
  logic        gap_ok;
  logic        load;
  logic        fan_or_batt;

  // BATT plays the table backwards; FANFARE and WARN play it forwards.
  function automatic logic [2:0] note_idx(
    input logic [1:0] s,
    input logic [2:0] k
  );
    if (s == SEQ_BATT) return 3'd5 - k;
    return k;
  endfunction

  function automatic logic [14:0] period_of(input logic [2:0] i);
    case (i)
      3'd0:    return 15'd31888;
      3'd1:    return 15'd23893;
      3'd2:    return 15'd18962;
      3'd3:    return 15'd15943;
      3'd4:    return 15'd18962;
      3'd5:    return 15'd15943;
      default: return 15'd0;
    endcase
  endfunction

  function automatic logic [25:0] dur_of(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: return 26'd8388608;
      3'd3:             return 26'd12582912;
      3'd4:             return 26'd4194304;
      3'd5:             return 26'd33554432;
      default:          return 26'd0;
    endcase
  endfunction

`ifdef PIEZO_ABORT_EN
  logic tf_q;
  logic abort_q, abort_d;
  logic tf_rise;
  assign tf_rise = too_fast & ~tf_q;
`endif

  assign fan_or_batt = (seq_q == SEQ_BATT) || (seq_q == SEQ_FAN);
  assign gap_sum = {1'b0, gap_q} + {1'b0, INC};
  assign gap_ok  = (gap_q >= REPEAT);

  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    step_d   = step_q;
    period_d = period_q;
    dur_d    = dur_q;
    gap_d    = gap_q;
    load     = 1'b0;
`ifdef PIEZO_ABORT_EN
    abort_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Saturate so the counter can sit idle indefinitely.
        if (gap_sum >= {1'b0, REPEAT}) gap_d = REPEAT;
        else                           gap_d = gap_sum[27:0];
        if (too_fast) begin
          seq_d   = SEQ_WARN;
          step_d  = 3'd0;
          state_d = ISSUE;
          load    = 1'b1;
        end else if (batt_low && gap_ok) begin
          seq_d   = SEQ_BATT;
          step_d  = 3'd0;
          state_d = ISSUE;
          load    = 1'b1;
        end else if (en_steer && gap_ok) begin
          seq_d   = SEQ_FAN;
          step_d  = 3'd0;
          state_d = ISSUE;
          load    = 1'b1;
        end
      end
      ISSUE: begin
        if (note_rdy) state_d = WAIT;
      end
      WAIT: begin
`ifdef PIEZO_ABORT_EN
        if (tf_rise && fan_or_batt) begin
          abort_d = 1'b1;
          seq_d   = SEQ_WARN;
          step_d  = 3'd0;
          state_d = ISSUE;
          load    = 1'b1;
        end else
`endif
        if (note_done) begin
          if (too_fast && seq_q != SEQ_WARN) begin
            seq_d   = SEQ_WARN;
            step_d  = 3'd0;
            state_d = ISSUE;
            load    = 1'b1;
          end else if (seq_q == SEQ_WARN) begin
            if (too_fast) begin
              step_d  = (step_q == 3'd2) ? 3'd0 : step_q + 3'd1;
              state_d = ISSUE;
              load    = 1'b1;
            end else begin
              seq_d   = SEQ_NONE;
              gap_d   = 28'd0;
              state_d = IDLE;
            end
          end else if (fan_or_batt && step_q != 3'd5) begin
            step_d  = step_q + 3'd1;
            state_d = ISSUE;
            load    = 1'b1;
          end else begin
            seq_d   = SEQ_NONE;
            gap_d   = 28'd0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Payload is latched on entry to ISSUE and held until accepted.
    if (load) begin
      period_d = period_of(note_idx(seq_d, step_d));
      dur_d    = dur_of(note_idx(seq_d, step_d));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      seq_q    <= SEQ_NONE;
      step_q   <= 3'd0;
      period_q <= 15'd0;
      dur_q    <= 26'd0;
      gap_q    <= 28'd0;
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      step_q   <= step_d;
      period_q <= period_d;
      dur_q    <= dur_d;
      gap_q    <= gap_d;
    end
  end

`ifdef PIEZO_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tf_q    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      tf_q    <= too_fast;
      abort_q <= abort_d;
    end
  end
  assign note_abort = abort_q;
`else
  assign note_abort = 1'b0;
`endif

  assign note_vld    = (state_q == ISSUE);
  assign note_period = period_q;
  assign note_dur    = dur_q;
  assign seq_id      = seq_q;
  assign busy        = (state_q != IDLE);

endmodule
